// File: rtl/axi_ethernet_v3_01_a_axi2ipic_bridge_pkg.sv
// rtl/axi_ethernet_v3_01_a_axi2ipic_bridge_pkg.sv - shared types and constants for the AXI4-Lite to IPIC bridge
package axi_ethernet_v3_01_a_axi2ipic_bridge_pkg;

  // Bridge FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_RESP = 3'd4
  } bridge_state_e;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Watchdog counter width: enough to hold C_TIMEOUT_CYCLES-1
  function automatic int tmo_cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/axi_ethernet_v3_01_a_ipic_watchdog.sv
// rtl/axi_ethernet_v3_01_a_ipic_watchdog.sv - cycle counter that flags an IPIC access which was never acknowledged
module axi_ethernet_v3_01_a_ipic_watchdog
  import axi_ethernet_v3_01_a_axi2ipic_bridge_pkg::*;
#(
  parameter int C_TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);

  localparam int            CW       = tmo_cnt_width(C_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(C_TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear on access start, count while the access is outstanding, saturate at the last value
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = enable_i && !clear_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/axi_ethernet_v3_01_a_axi2ipic_bridge.sv
// rtl/axi_ethernet_v3_01_a_axi2ipic_bridge.sv - AXI4-Lite slave to IPIC initiator bridge for the TEMAC register space
module axi_ethernet_v3_01_a_axi2ipic_bridge
  import axi_ethernet_v3_01_a_axi2ipic_bridge_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [31:0]                   s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [31:0]                   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] bus2ip_addr,
  output logic [31:0]                   bus2ip_data,
  output logic [3:0]                    bus2ip_be,
  output logic                          bus2ip_rnw,
  output logic                          bus2ip_cs,
  output logic                          bus2ip_rdce,
  output logic                          bus2ip_wrce,
  input  logic                          ip2bus_rdack,
  input  logic                          ip2bus_wrack,
  input  logic                          ip2bus_error,
  input  logic [31:0]                   ip2bus_data
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;

  bridge_state_e   state_q;
  logic            rd_prio_q;   // 1: read wins the next simultaneous request
  logic [AW-1:0]   addr_q;
  logic [31:0]     data_q;
  logic [3:0]      be_q;
  logic            rnw_q;
  logic            cs_q;
  logic            rdce_q;
  logic            wrce_q;
  logic            bvalid_q;
  logic [1:0]      bresp_q;
  logic            rvalid_q;
  logic [1:0]      rresp_q;
  logic [31:0]     rdata_q;

  logic idle;
  logic wr_req;
  logic rd_req;
  logic grant_wr;
  logic grant_rd;
  logic tmo;
  logic wr_done;
  logic rd_done;
  logic unused_addr_lsbs;

  // Only a complete AW+W pair counts as a write request; ties are broken round-robin
  assign idle     = s_axi_aresetn && (state_q == ST_IDLE);
  assign wr_req   = s_axi_awvalid && s_axi_wvalid;
  assign rd_req   = s_axi_arvalid;
  assign grant_wr = idle && wr_req && (!rd_req || !rd_prio_q);
  assign grant_rd = idle && rd_req && (!wr_req || rd_prio_q);

  assign s_axi_awready = grant_wr;
  assign s_axi_wready  = grant_wr;
  assign s_axi_arready = grant_rd;

  // Only the ack matching the access type, or an error, or the watchdog ends an access
  assign wr_done = (state_q == ST_WRITE) && (ip2bus_wrack || ip2bus_error || tmo);
  assign rd_done = (state_q == ST_READ)  && (ip2bus_rdack || ip2bus_error || tmo);

  axi_ethernet_v3_01_a_ipic_watchdog #(
    .C_TIMEOUT_CYCLES (C_TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (s_axi_aclk),
    .rst_n_i   (s_axi_aresetn),
    .clear_i   (grant_wr || grant_rd),
    .enable_i  ((state_q == ST_WRITE) || (state_q == ST_READ)),
    .timeout_o (tmo)
  );

  // Bridge FSM with registered IPIC strobes and AXI responses
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= ST_IDLE;
      rd_prio_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
      rnw_q     <= 1'b1;
      cs_q      <= 1'b0;
      rdce_q    <= 1'b0;
      wrce_q    <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_wr) begin
            state_q   <= ST_WRITE;
            rd_prio_q <= 1'b1;
            addr_q    <= {s_axi_awaddr[AW-1:2], 2'b00};
            data_q    <= s_axi_wdata;
            be_q      <= s_axi_wstrb;
            rnw_q     <= 1'b0;
            cs_q      <= 1'b1;
            wrce_q    <= 1'b1;
          end else if (grant_rd) begin
            state_q   <= ST_READ;
            rd_prio_q <= 1'b0;
            addr_q    <= {s_axi_araddr[AW-1:2], 2'b00};
            be_q      <= 4'hF;
            rnw_q     <= 1'b1;
            cs_q      <= 1'b1;
            rdce_q    <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (wr_done) begin
            state_q  <= ST_WR_RESP;
            cs_q     <= 1'b0;
            wrce_q   <= 1'b0;
            rnw_q    <= 1'b1;
            bvalid_q <= 1'b1;
            // A forced termination is an error unless the ack landed in the same cycle
            bresp_q  <= (ip2bus_error || (tmo && !ip2bus_wrack)) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        ST_READ: begin
          if (rd_done) begin
            state_q  <= ST_RD_RESP;
            cs_q     <= 1'b0;
            rdce_q   <= 1'b0;
            rvalid_q <= 1'b1;
            rresp_q  <= (ip2bus_error || (tmo && !ip2bus_rdack)) ? RESP_SLVERR : RESP_OKAY;
            rdata_q  <= ip2bus_rdack ? ip2bus_data : 32'h0;
          end
        end
        ST_WR_RESP: begin
          if (s_axi_bready) begin
            state_q  <= ST_IDLE;
            bvalid_q <= 1'b0;
          end
        end
        ST_RD_RESP: begin
          if (s_axi_rready) begin
            state_q  <= ST_IDLE;
            rvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = rdata_q;
  assign bus2ip_addr  = addr_q;
  assign bus2ip_data  = data_q;
  assign bus2ip_be    = be_q;
  assign bus2ip_rnw   = rnw_q;
  assign bus2ip_cs    = cs_q;
  assign bus2ip_rdce  = rdce_q;
  assign bus2ip_wrce  = wrce_q;

  // Byte-lane bits of the AXI addresses are dropped; accesses are word aligned
  assign unused_addr_lsbs = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi_ethernet_v3_01_a_axi2ipic_bridge.sv
// tb/tb_axi_ethernet_v3_01_a_axi2ipic_bridge.sv - directed self-checking bench for the AXI4-Lite to IPIC bridge
module tb_axi_ethernet_v3_01_a_axi2ipic_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [11:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [11:0] ip_addr;
  logic [31:0] ip_wdata;
  logic [3:0]  ip_be;
  logic        ip_rnw;
  logic        ip_cs;
  logic        ip_rdce;
  logic        ip_wrce;
  logic        rdack;
  logic        wrack;
  logic        err;
  logic [31:0] ip_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_ethernet_v3_01_a_axi2ipic_bridge #(
    .C_S_AXI_ADDR_WIDTH (12),
    .C_TIMEOUT_CYCLES   (64)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .bus2ip_addr   (ip_addr),
    .bus2ip_data   (ip_wdata),
    .bus2ip_be     (ip_be),
    .bus2ip_rnw    (ip_rnw),
    .bus2ip_cs     (ip_cs),
    .bus2ip_rdce   (ip_rdce),
    .bus2ip_wrce   (ip_wrce),
    .ip2bus_rdack  (rdack),
    .ip2bus_wrack  (wrack),
    .ip2bus_error  (err),
    .ip2bus_data   (ip_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cs"}, 32'(ip_cs), 32'd0);
    chk({tag, "_rdce"}, 32'(ip_rdce), 32'd0);
    chk({tag, "_wrce"}, 32'(ip_wrce), 32'd0);
    chk({tag, "_rnw"}, 32'(ip_rnw), 32'd1);
    chk({tag, "_addr"}, 32'(ip_addr), 32'd0);
    chk({tag, "_bvalid"}, 32'(bvalid), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_arready"}, 32'(arready), 32'd0);
  endtask

  initial begin
    int n;
    int guard;
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    rdack = 1'b0; wrack = 1'b0; err = 1'b0; ip_rdata = '0;

    // Reset values
    repeat (3) tick();
    @(negedge clk);
    chk_idle_outputs("rst");
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_be", 32'(ip_be), 32'd0);
    chk("rst_wdata", ip_wdata, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Write 0x404 = 0xDEADBEEF, wrack at T+3
    awaddr = 12'h404; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("w1_awready", 32'(awready), 32'd1);
    chk("w1_wready", 32'(wready), 32'd1);
    chk("w1_wrce_T", 32'(ip_wrce), 32'd0);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("w1_wrce_T1", 32'(ip_wrce), 32'd1);
    chk("w1_cs_T1", 32'(ip_cs), 32'd1);
    chk("w1_rnw", 32'(ip_rnw), 32'd0);
    chk("w1_addr", 32'(ip_addr), 32'h404);
    chk("w1_data", ip_wdata, 32'hDEADBEEF);
    chk("w1_be", 32'(ip_be), 32'hF);
    chk("w1_awready_busy", 32'(awready), 32'd0);
    tick();
    @(negedge clk);
    chk("w1_wrce_T2", 32'(ip_wrce), 32'd1);
    tick();
    wrack = 1'b1;
    @(negedge clk);
    chk("w1_wrce_T3", 32'(ip_wrce), 32'd1);
    chk("w1_bvalid_T3", 32'(bvalid), 32'd0);
    tick();
    wrack = 1'b0;
    @(negedge clk);
    chk("w1_bvalid_T4", 32'(bvalid), 32'd1);
    chk("w1_bresp", 32'(bresp), 32'd0);
    chk("w1_wrce_T4", 32'(ip_wrce), 32'd0);
    chk("w1_cs_T4", 32'(ip_cs), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    @(negedge clk);
    chk("w1_bvalid_done", 32'(bvalid), 32'd0);

    // Read 0x208, rdack with data; a wrong-type wrack first is ignored
    tick();
    araddr = 12'h208; arvalid = 1'b1;
    @(negedge clk);
    chk("r1_arready", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    wrack = 1'b1;
    @(negedge clk);
    chk("r1_rdce", 32'(ip_rdce), 32'd1);
    chk("r1_rnw", 32'(ip_rnw), 32'd1);
    chk("r1_addr", 32'(ip_addr), 32'h208);
    chk("r1_be", 32'(ip_be), 32'hF);
    tick();
    wrack = 1'b0;
    rdack = 1'b1; ip_rdata = 32'h12345678;
    @(negedge clk);
    chk("r1_wrongack_ignored", 32'(rvalid), 32'd0);
    chk("r1_rdce_ack", 32'(ip_rdce), 32'd1);
    tick();
    rdack = 1'b0; ip_rdata = 32'h0;
    @(negedge clk);
    chk("r1_rvalid", 32'(rvalid), 32'd1);
    chk("r1_rdata", rdata, 32'h12345678);
    chk("r1_rresp", 32'(rresp), 32'd0);
    chk("r1_rdce_drop", 32'(ip_rdce), 32'd0);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    @(negedge clk);
    chk("r1_rvalid_done", 32'(rvalid), 32'd0);

    // Write 0x100 with no ack: watchdog terminates after 64 strobe cycles
    tick();
    awaddr = 12'h100; wdata = 32'h0000_00A5; wstrb = 4'h3; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("w2_awready", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    guard = 0;
    while (guard < 200) begin
      @(negedge clk);
      if (bvalid) break;
      if (ip_wrce) n++;
      guard++;
      tick();
    end
    chk("w2_tmo_no_hang", 32'(guard < 200), 32'd1);
    chk("w2_wrce_cycles", 32'(n), 32'd64);
    chk("w2_bresp", 32'(bresp), 32'd2);
    chk("w2_wrce_drop", 32'(ip_wrce), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // Read 0x600 with error and rdack together
    tick();
    araddr = 12'h600; arvalid = 1'b1;
    @(negedge clk);
    chk("r2_arready", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    rdack = 1'b1; err = 1'b1; ip_rdata = 32'hAAAA5555;
    tick();
    rdack = 1'b0; err = 1'b0; ip_rdata = 32'h0;
    @(negedge clk);
    chk("r2_rvalid", 32'(rvalid), 32'd1);
    chk("r2_rresp", 32'(rresp), 32'd2);
    rready = 1'b1;
    tick();
    rready = 1'b0;

    // Simultaneous read and write: write wins, read follows; bready held low 5 cycles
    tick();
    awaddr = 12'h00C; wdata = 32'h0BAD_F00D; wstrb = 4'h8; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 12'h014; arvalid = 1'b1;
    @(negedge clk);
    chk("rr_awready", 32'(awready), 32'd1);
    chk("rr_arready_lose", 32'(arready), 32'd0);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("rr_wrce", 32'(ip_wrce), 32'd1);
    chk("rr_be", 32'(ip_be), 32'h8);
    chk("rr_arready_busy", 32'(arready), 32'd0);
    tick();
    wrack = 1'b1;
    tick();
    wrack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_bvalid_hold", 32'(bvalid), 32'd1);
      chk("rr_bresp_hold", 32'(bresp), 32'd0);
      chk("rr_arready_hold", 32'(arready), 32'd0);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    @(negedge clk);
    chk("rr_bvalid_done", 32'(bvalid), 32'd0);
    chk("rr_arready_next", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    @(negedge clk);
    chk("rr_rdce", 32'(ip_rdce), 32'd1);
    chk("rr_raddr", 32'(ip_addr), 32'h014);
    tick();
    rdack = 1'b1; ip_rdata = 32'hCAFE0001;
    tick();
    rdack = 1'b0; ip_rdata = 32'h0;
    @(negedge clk);
    chk("rr_rdata", rdata, 32'hCAFE0001);
    rready = 1'b1;
    tick();
    rready = 1'b0;

    // Asynchronous reset while rdce is high, then a stray rdack
    tick();
    araddr = 12'h0F0; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    @(negedge clk);
    chk("ar_rdce_before", 32'(ip_rdce), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("ar");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    rdack = 1'b1; ip_rdata = 32'h55AA55AA;
    tick();
    rdack = 1'b0; ip_rdata = 32'h0;
    @(negedge clk);
    chk("ar_no_rvalid", 32'(rvalid), 32'd0);
    chk("ar_no_rdce", 32'(ip_rdce), 32'd0);
    tick();
    @(negedge clk);
    chk("ar_no_rvalid2", 32'(rvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
